// File: rtl/serpent_xts_tweak_stage.sv
// XTS tweak whitening around a Serpent decrypt core: pre/post XOR with T and
// alpha-multiplication of T per block, one block in flight.
module serpent_xts_tweak_stage #(
    parameter int unsigned BLOCKS_PER_SECTOR = 32,
    parameter int unsigned TIMEOUT_CYCLES    = 64
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_sector_start,
    input  logic [127:0] i_tweak,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_data,
    output logic         o_core_rstn,
    output logic         o_core_en,
    output logic [127:0] o_core_data,
    input  logic [127:0] i_core_data,
    input  logic         i_core_valid,
    output logic [7:0]   o_block_cnt,
    output logic         o_error
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {StNoTweak, StReady, StClr, StLaunch, StWait, StOut} state_e;

    state_e          state_q, state_d;
    logic [127:0]    tweak_q, tweak_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [127:0]    out_data_q, out_data_d;
    logic            core_rstn_q, core_rstn_d;
    logic            core_en_q, core_en_d;
    logic [127:0]    core_data_q, core_data_d;
    logic [7:0]      block_cnt_q, block_cnt_d;
    logic            error_q, error_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic       in_hs, out_hs, tmo_hit, last_blk;
    logic [7:0] cnt_inc;

    // in_ready is only ever high in StReady, so it doubles as the state qualifier
    assign in_hs    = i_in_valid & in_ready_q;
    assign out_hs   = out_valid_q & i_out_ready;
    assign tmo_hit  = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
    assign cnt_inc  = block_cnt_q + 8'd1;
    assign last_blk = (cnt_inc == 8'(BLOCKS_PER_SECTOR));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= StNoTweak;
            tweak_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            core_rstn_q <= 1'b1;
            core_en_q   <= 1'b0;
            core_data_q <= '0;
            block_cnt_q <= '0;
            error_q     <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            tweak_q     <= tweak_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            core_rstn_q <= core_rstn_d;
            core_en_q   <= core_en_d;
            core_data_q <= core_data_d;
            block_cnt_q <= block_cnt_d;
            error_q     <= error_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StNoTweak: if (i_sector_start) state_d = StReady;
            StReady:   if (in_hs) state_d = StClr;
            StClr:     state_d = StLaunch;
            StLaunch:  state_d = StWait;
            StWait: begin
                if (i_core_valid) state_d = StOut;
                else if (tmo_hit) state_d = StNoTweak;
            end
            StOut:     if (out_hs) state_d = last_blk ? StNoTweak : StReady;
            default:   state_d = StNoTweak;
        endcase
    end

    always_comb begin
        tweak_d     = tweak_q;
        out_data_d  = out_data_q;
        core_data_d = core_data_q;
        block_cnt_d = block_cnt_q;
        error_d     = error_q;
        tmo_d       = tmo_q;
        in_ready_d  = (state_d == StReady);
        out_valid_d = (state_d == StOut);
        core_rstn_d = (state_d != StClr);
        core_en_d   = (state_d == StWait);
        unique case (state_q)
            StNoTweak: begin
                if (i_sector_start) begin
                    tweak_d     = i_tweak;
                    block_cnt_d = '0;
                end
            end
            StReady: begin
                // A handshake in the same cycle as a sector start takes priority
                if (in_hs) begin
                    core_data_d = i_in_data ^ tweak_q;
                end else if (i_sector_start) begin
                    tweak_d     = i_tweak;
                    block_cnt_d = '0;
                end
            end
            StLaunch: tmo_d = '0;
            StWait: begin
                tmo_d = tmo_q + TmoW'(1);
                if (i_core_valid) begin
                    out_data_d = i_core_data ^ tweak_q;
                end else if (tmo_hit) begin
                    error_d = 1'b1;
                end
            end
            StOut: begin
                if (out_hs) begin
                    tweak_d     = {tweak_q[126:0], 1'b0} ^ {120'b0, 8'h87 & {8{tweak_q[127]}}};
                    block_cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_data_q;
    assign o_core_rstn = core_rstn_q;
    assign o_core_en   = core_en_q;
    assign o_core_data = core_data_q;
    assign o_block_cnt = block_cnt_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_serpent_xts_tweak_stage.sv
// Bench for serpent_xts_tweak_stage: behavioural core model plus a byte-wise
// XTS tweak model, randomized data and tweaks.
module tb_serpent_xts_tweak_stage;

    localparam int          Bps     = 2;
    localparam int          Tmo     = 64;
    localparam int          CoreLat = 35;
    localparam logic [127:0] Mask   = {4{32'hA5A5A5A5}};

    logic         i_clk = 1'b0;
    logic         i_rstn = 1'b0;
    logic         i_sector_start = 1'b0;
    logic [127:0] i_tweak = '0;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [127:0] i_in_data = '0;
    logic         o_out_valid;
    logic         i_out_ready = 1'b0;
    logic [127:0] o_out_data;
    logic         o_core_rstn;
    logic         o_core_en;
    logic [127:0] o_core_data;
    logic [127:0] core_res;
    logic         core_valid;
    logic [7:0]   o_block_cnt;
    logic         o_error;

    int checks = 0;
    int passes = 0;
    logic [127:0] model_t;
    int           model_cnt;
    bit           core_dead = 1'b0;
    int           core_cnt;

    always #5 i_clk = ~i_clk;

    serpent_xts_tweak_stage #(
        .BLOCKS_PER_SECTOR(Bps),
        .TIMEOUT_CYCLES   (Tmo)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_sector_start(i_sector_start),
        .i_tweak       (i_tweak),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_in_data     (i_in_data),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_data    (o_out_data),
        .o_core_rstn   (o_core_rstn),
        .o_core_en     (o_core_en),
        .o_core_data   (o_core_data),
        .i_core_data   (core_res),
        .i_core_valid  (core_valid),
        .o_block_cnt   (o_block_cnt),
        .o_error       (o_error)
    );

    // Decrypt core stand-in: fixed latency after enable, sticky valid until cleared
    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            core_cnt   <= 0;
            core_valid <= 1'b0;
            core_res   <= '0;
        end else if (!o_core_rstn) begin
            core_cnt   <= 0;
            core_valid <= 1'b0;
        end else if (o_core_en && !core_valid && !core_dead) begin
            if (core_cnt == CoreLat - 1) begin
                core_valid <= 1'b1;
                core_res   <= o_core_data ^ Mask;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    // XTS multiply-by-alpha over little-endian bytes, carry rippling upward
    function automatic logic [127:0] mul_alpha(input logic [127:0] t);
        logic [127:0] r;
        logic [7:0]   b;
        logic         carry, nc;
        carry = 1'b0;
        r     = '0;
        for (int i = 0; i < 16; i++) begin
            b             = t[8*i +: 8];
            nc            = b[7];
            r[8*i +: 8]   = {b[6:0], carry};
            carry         = nc;
        end
        if (carry) r[7:0] = r[7:0] ^ 8'h87;
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_sector_start(input logic [127:0] tw);
        i_sector_start = 1'b1;
        i_tweak        = tw;
        @(posedge i_clk);
        #1;
        i_sector_start = 1'b0;
        @(negedge i_clk);
        model_t   = tw;
        model_cnt = 0;
    endtask

    task automatic accept_out();
        i_out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b0;
        @(negedge i_clk);
        model_t   = mul_alpha(model_t);
        model_cnt = model_cnt + 1;
    endtask

    task automatic send_block(input logic [127:0] d, input bit start_too,
                              input logic [127:0] st_tweak, output bit ok,
                              output logic [127:0] cd, output logic [127:0] od,
                              output int rlow, output int rlow_at_en, output int en_cyc);
        int n;
        bit seen_en;
        ok = 1'b0; cd = '0; od = '0; rlow = 0; rlow_at_en = -1; en_cyc = 0; seen_en = 1'b0;
        i_in_valid = 1'b1;
        i_in_data  = d;
        n = 0;
        while (o_in_ready !== 1'b1 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (o_in_ready !== 1'b1) begin
            i_in_valid = 1'b0;
            return;
        end
        if (start_too) begin
            i_sector_start = 1'b1;
            i_tweak        = st_tweak;
        end
        @(posedge i_clk);
        #1;
        i_in_valid     = 1'b0;
        i_sector_start = 1'b0;
        n = 0;
        while (o_out_valid !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
            if (o_core_rstn === 1'b0) rlow++;
            if (o_core_en === 1'b1) begin
                en_cyc++;
                if (!seen_en) begin
                    seen_en    = 1'b1;
                    cd         = o_core_data;
                    rlow_at_en = rlow;
                end
            end
        end
        ok = (o_out_valid === 1'b1);
        od = o_out_data;
    endtask

    task automatic test_reset();
        logic [268:0] got, want;
        want = {1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 128'h0, 8'h0, 1'b0};
        repeat (3) @(negedge i_clk);
        got = {o_in_ready, o_out_valid, o_out_data, o_core_rstn, o_core_en, o_core_data,
               o_block_cnt, o_error};
        checks++; if (got !== want) $display("FAIL reset_vals: got %h want %h", got, want);
        else passes++;
        i_rstn = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++; if (o_in_ready !== 1'b0) $display("FAIL notweak_ready: got %b want 0", o_in_ready);
        else passes++;
    endtask

    task automatic test_basic();
        bit ok; logic [127:0] cd, od; int rl, rle, ec;
        do_sector_start(128'h1);
        for (int b = 0; b < 2; b++) begin
            send_block(128'h0, 1'b0, '0, ok, cd, od, rl, rle, ec);
            checks++; if (!ok) $display("FAIL basic_valid[%0d]: got %b want 1", b, ok);
            else passes++;
            checks++; if (cd !== model_t) $display("FAIL basic_core_data[%0d]: got %h want %h", b, cd, model_t);
            else passes++;
            checks++; if (od !== Mask) $display("FAIL basic_out[%0d]: got %h want %h", b, od, Mask);
            else passes++;
            checks++; if (rl != 1 || rle != 1)
                $display("FAIL basic_core_clr[%0d]: got %0d/%0d want 1/1", b, rl, rle);
            else passes++;
            accept_out();
            checks++; if (o_block_cnt !== 8'(model_cnt))
                $display("FAIL basic_cnt[%0d]: got %0d want %0d", b, o_block_cnt, model_cnt);
            else passes++;
        end
    endtask

    task automatic test_sector_end();
        bit seen_ready = 1'b0;
        bit seen_clr   = 1'b0;
        i_in_valid = 1'b1;
        i_in_data  = rand128();
        repeat (20) begin
            @(negedge i_clk);
            if (o_in_ready === 1'b1) seen_ready = 1'b1;
            if (o_core_rstn === 1'b0) seen_clr = 1'b1;
        end
        i_in_valid = 1'b0;
        checks++; if (seen_ready || seen_clr)
            $display("FAIL end_no_accept: got ready=%b clr=%b want 0/0", seen_ready, seen_clr);
        else passes++;
        checks++; if (o_block_cnt !== 8'd2) $display("FAIL end_cnt: got %0d want 2", o_block_cnt);
        else passes++;
        do_sector_start(rand128());
        checks++; if (o_block_cnt !== 8'd0 || o_in_ready !== 1'b1)
            $display("FAIL end_restart: got cnt=%0d ready=%b want 0/1", o_block_cnt, o_in_ready);
        else passes++;
    endtask

    task automatic test_alpha();
        bit ok; logic [127:0] cd, od, d; int rl, rle, ec;
        do_sector_start(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        for (int b = 0; b < 2; b++) begin
            d = rand128();
            send_block(d, 1'b0, '0, ok, cd, od, rl, rle, ec);
            checks++; if (cd !== (d ^ model_t))
                $display("FAIL alpha_core_data[%0d]: got %h want %h", b, cd, d ^ model_t);
            else passes++;
            checks++; if (od !== (d ^ Mask)) $display("FAIL alpha_out[%0d]: got %h want %h", b, od, d ^ Mask);
            else passes++;
            accept_out();
        end
    endtask

    task automatic test_backpressure();
        bit ok, stable; logic [127:0] cd, od, d, t0; int rl, rle, ec;
        do_sector_start(rand128());
        t0 = model_t;
        d  = rand128();
        send_block(d, 1'b0, '0, ok, cd, od, rl, rle, ec);
        stable = ok;
        repeat (10) begin
            @(negedge i_clk);
            if (o_out_valid !== 1'b1 || o_out_data !== od || o_in_ready !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable || od !== (d ^ Mask))
            $display("FAIL bp_hold: got stable=%b out=%h want 1 %h", stable, od, d ^ Mask);
        else passes++;
        accept_out();
        d = rand128();
        send_block(d, 1'b0, '0, ok, cd, od, rl, rle, ec);
        checks++; if (cd !== (d ^ mul_alpha(t0)))
            $display("FAIL bp_tweak_once: got %h want %h", cd, d ^ mul_alpha(t0));
        else passes++;
        accept_out();
    endtask

    task automatic test_restart_in_ready();
        bit ok; logic [127:0] cd, od, d, tw2; int rl, rle, ec;
        do_sector_start(rand128());
        send_block(rand128(), 1'b0, '0, ok, cd, od, rl, rle, ec);
        accept_out();
        tw2 = rand128();
        do_sector_start(tw2);
        checks++; if (o_block_cnt !== 8'd0) $display("FAIL rs_cnt_clear: got %0d want 0", o_block_cnt);
        else passes++;
        d = rand128();
        send_block(d, 1'b0, '0, ok, cd, od, rl, rle, ec);
        checks++; if (cd !== (d ^ tw2)) $display("FAIL rs_reload: got %h want %h", cd, d ^ tw2);
        else passes++;
        accept_out();
        // sector start coincident with handshake must be dropped
        d = rand128();
        send_block(d, 1'b1, rand128(), ok, cd, od, rl, rle, ec);
        checks++; if (cd !== (d ^ model_t)) $display("FAIL rs_hs_wins: got %h want %h", cd, d ^ model_t);
        else passes++;
        accept_out();
        checks++; if (o_block_cnt !== 8'd2 || o_in_ready !== 1'b0)
            $display("FAIL rs_cnt_end: got cnt=%0d ready=%b want 2/0", o_block_cnt, o_in_ready);
        else passes++;
    endtask

    task automatic test_random();
        bit ok; logic [127:0] cd, od, d; int rl, rle, ec;
        for (int s = 0; s < 3; s++) begin
            do_sector_start(rand128());
            for (int b = 0; b < Bps; b++) begin
                d = rand128();
                send_block(d, 1'b0, '0, ok, cd, od, rl, rle, ec);
                checks++; if (cd !== (d ^ model_t) || od !== (d ^ Mask))
                    $display("FAIL rand_blk[%0d.%0d]: got %h/%h want %h/%h", s, b, cd, od,
                             d ^ model_t, d ^ Mask);
                else passes++;
                accept_out();
                checks++; if (o_block_cnt !== 8'(model_cnt))
                    $display("FAIL rand_cnt[%0d.%0d]: got %0d want %0d", s, b, o_block_cnt, model_cnt);
                else passes++;
            end
        end
    endtask

    task automatic test_timeout();
        bit ok; logic [127:0] cd, od, d; int rl, rle, ec;
        core_dead = 1'b1;
        do_sector_start(rand128());
        send_block(rand128(), 1'b0, '0, ok, cd, od, rl, rle, ec);
        checks++; if (ok || ec != Tmo)
            $display("FAIL tmo_wait: got valid=%b en_cycles=%0d want 0/%0d", ok, ec, Tmo);
        else passes++;
        checks++; if (o_error !== 1'b1 || o_core_en !== 1'b0 || o_in_ready !== 1'b0)
            $display("FAIL tmo_state: got err=%b en=%b ready=%b want 1/0/0", o_error, o_core_en, o_in_ready);
        else passes++;
        repeat (20) @(negedge i_clk);
        checks++; if (o_error !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", o_error);
        else passes++;
        core_dead = 1'b0;
        do_sector_start(rand128());
        d = rand128();
        send_block(d, 1'b0, '0, ok, cd, od, rl, rle, ec);
        checks++; if (!ok || cd !== (d ^ model_t) || o_error !== 1'b1)
            $display("FAIL tmo_resume: got ok=%b cd=%h err=%b want 1 %h 1", ok, cd, o_error, d ^ model_t);
        else passes++;
        accept_out();
    endtask

    task automatic test_reset_mid();
        logic [268:0] got, want;
        int n;
        want = {1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 128'h0, 8'h0, 1'b0};
        do_sector_start(rand128());
        i_in_valid = 1'b1;
        i_in_data  = rand128();
        n = 0;
        while (o_in_ready !== 1'b1 && n < 50) begin @(negedge i_clk); n++; end
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        n = 0;
        while (o_core_en !== 1'b1 && n < 50) begin @(negedge i_clk); n++; end
        checks++; if (o_core_en !== 1'b1) $display("FAIL mid_reach_wait: got %b want 1", o_core_en);
        else passes++;
        repeat (5) @(negedge i_clk);
        i_rstn = 1'b0;
        #1;
        got = {o_in_ready, o_out_valid, o_out_data, o_core_rstn, o_core_en, o_core_data,
               o_block_cnt, o_error};
        checks++; if (got !== want) $display("FAIL mid_reset_vals: got %h want %h", got, want);
        else passes++;
        @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (5) @(negedge i_clk);
        checks++; if (o_in_ready !== 1'b0 || o_core_en !== 1'b0)
            $display("FAIL mid_idle: got ready=%b en=%b want 0/0", o_in_ready, o_core_en);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sector_end();
        test_alpha();
        test_backpressure();
        test_restart_in_ready();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
